muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
//  Sits in EX beside the ALU and takes the forwarded regfile operands (rd1 -> a, rd2 -> b).
//  Executes MULT/MULTU/DIV/DIVU over multiple cycles; MTHI/MTLO complete in one cycle.
//  hi/lo feed the MFHI/MFLO writeback mux. busy feeds the hazard unit for stalls.
// PARAMETERS
//  WIDTH    32   operand/result width; iteration count = WIDTH
// PORTS
//  clk      in   1        clock; all state updates on the rising edge
//  reset    in   1        asynchronous, active-high; clears all state
//  start    in   1        issue strobe; sampled on a rising edge of clk only when busy=0
//  op       in   3        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//  a        in   WIDTH    rs operand (dividend / multiplicand / MTHI-MTLO data)
//  b        in   WIDTH    rt operand (divisor / multiplier)
//  flush    in   1        aborts the in-flight op (branch or exception squash)
//  busy     out  1        multi-cycle op in flight
//  done     out  1        one-cycle pulse: hi/lo now hold the new result
//  hi       out  WIDTH    HI register
//  lo       out  WIDTH    LO register
// BEHAVIOUR
//  - Reset (async): hi=0, lo=0, busy=0, done=0, state=IDLE. Any in-flight op is lost.
//  - FSM states are IDLE, RUN and FIX. busy=1 exactly when state is RUN or FIX.
//  - IDLE, start=1, MULT/MULTU/DIV/DIVU, flush=0:
//      latch |a| and |b| (magnitudes for signed ops, raw values for unsigned ops);
//      latch the sign flags; clear the counter; go to RUN.
//  - RUN: one radix-2 step per cycle.
//      multiply = shift-add into a 2*WIDTH accumulator.
//      divide   = restoring shift-subtract.
//      After WIDTH steps, go to FIX.
//  - FIX: apply the sign correction.
//      product negated if the operand signs differ;
//      quotient negated if the operand signs differ;
//      remainder takes the sign of the dividend.
//      Write hi/lo: product upper->hi, lower->lo; remainder->hi, quotient->lo.
//      done=1 for one cycle; return to IDLE.
//  - Latency: start accepted at edge E0 -> busy=1 after E0; new hi/lo and done=1 after E(WIDTH+1).
//    This is 33 cycles at WIDTH=32. busy=0 in the same cycle that done=1.
//  - hi/lo keep their old values while busy; the working registers are separate from hi/lo.
//  - MTHI/MTLO with start=1 in IDLE: hi (or lo) <= a at E0, done=1 after E0, busy never asserted.
//  - Op codes 11x: done=1 after E0, nothing else changes.
//  - start while busy=1 is ignored; no queueing. The hazard unit must hold the instruction.
//  - flush=1: state -> IDLE at the next edge; busy=0, done=0, hi/lo unchanged.
//    If flush and start are asserted in the same cycle, flush wins.
//    flush has no effect on a MTHI/MTLO write issued in an earlier cycle.
//  - Divide by zero (b=0, DIV or DIVU): full latency; hi=a, lo={WIDTH{1'b1}}.
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap, no trap).
//  - All arithmetic is modulo 2^WIDTH per half; no overflow flags.
// CONFIGURATION
//  MULDIV_DIV_EN defined:
//    - full divider datapath is present; DIV/DIVU behave as described above.
//  MULDIV_DIV_EN undefined:
//    - no divider logic is built;
//    - DIV/DIVU act like a 11x no-op: done=1 after E0, busy never set, hi/lo unchanged.
// TESTING
//  1. MULTU a=0xFFFFFFFF b=2 -> busy for 33 cycles, then hi=0x00000001, lo=0xFFFFFFFE, done high 1 cycle.
//  2. MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB(-21).
//  3. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU a=7 b=0 -> hi=7, lo=0xFFFFFFFF.
//     Without MULDIV_DIV_EN: done after 1 cycle, hi/lo unchanged.
//  4. MULT running, second start at cycle 5 -> ignored.
//     flush at cycle 10 -> busy=0 next edge, no done pulse, hi/lo keep the old values.
//  5. MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 back-to-back -> hi/lo updated one edge each,
//     done high on both cycles, busy stays 0.
//  6. reset pulsed mid-RUN (cycle 17), asynchronous to clk -> hi=lo=0, busy=done=0 immediately.
//     A new MULTU 3*5 then yields lo=15, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Optional divider datapath is built only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q;
   logic [2*WIDTH-1:0]  acc_q;
   logic [WIDTH-1:0]    opb_q;
   logic [WIDTH-1:0]    hi_q, lo_q;
   logic                neg_q;
   logic                done_q;

   logic                is_signed, sign_a, sign_b;
   logic                is_mul_op, is_iter, accept;
   logic [WIDTH-1:0]    mag_a, mag_b;
   logic [WIDTH:0]      mul_sum;
   logic [2*WIDTH-1:0]  mul_next, step_next, prod;

   assign is_signed = ~op[0];
   assign sign_a    = is_signed & a[WIDTH-1];
   assign sign_b    = is_signed & b[WIDTH-1];
   assign mag_a     = sign_a ? -a : a;
   assign mag_b     = sign_b ? -b : b;
   assign is_mul_op = (op[2:1] == 2'b00);
   assign accept    = start & ~flush & (state_q == IDLE);

   // Shift-add: multiplier sits in the low half and is consumed LSB first.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
   assign prod     = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
   logic                is_div_q, rneg_q;
   logic [WIDTH:0]      div_diff;
   logic [2*WIDTH-1:0]  div_next;
   logic [WIDTH-1:0]    quo, rem;

   // Restoring divide: remainder in the high half, dividend shifts out / quotient shifts in low.
   assign div_diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
   assign div_next  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   assign quo       = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem       = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   assign is_iter   = ~op[2];
   assign step_next = is_div_q ? div_next : mul_next;
`else
   assign is_iter   = is_mul_op;
   assign step_next = mul_next;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && is_iter) state_d = RUN;
         RUN:     if (cnt_q == LAST) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         opb_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         neg_q  <= 1'b0;
         done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div_q <= 1'b0;
         rneg_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            if (is_mul_op) begin
               acc_q <= {{WIDTH{1'b0}}, mag_b};
               opb_q <= mag_a;
               neg_q <= sign_a ^ sign_b;
               cnt_q <= '0;
`ifdef MULDIV_DIV_EN
               is_div_q <= 1'b0;
`endif
            end
`ifdef MULDIV_DIV_EN
            else if (op[2:1] == 2'b01) begin
               acc_q    <= {{WIDTH{1'b0}}, mag_a};
               opb_q    <= mag_b;
               // Divide by zero keeps the all-ones quotient regardless of dividend sign.
               neg_q    <= (sign_a ^ sign_b) & (b != '0);
               rneg_q   <= sign_a;
               is_div_q <= 1'b1;
               cnt_q    <= '0;
            end
`endif
            else begin
               done_q <= 1'b1;
               if (op == 3'b100)      hi_q <= a;
               else if (op == 3'b101) lo_q <= a;
            end
         end else if (state_q == RUN && !flush) begin
            acc_q <= step_next;
            cnt_q <= cnt_q + 1'b1;
         end else if (state_q == FIX && !flush) begin
            done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
               hi_q <= rem;
               lo_q <= quo;
            end else
`endif
            begin
               hi_q <= prod[2*WIDTH-1:WIDTH];
               lo_q <= prod[WIDTH-1:0];
            end
         end
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule
